// File: rtl/tri_seq_monitor.sv
// Sequence monitor for a 3-bit up/down triangle counter: locks onto the ramp, flags violations, measures periods.
// Optional: define TRI_SEQ_MON_STALL_EN to ignore repeated samples while locked.
module tri_seq_monitor (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_count,
    output logic       lock,
    output logic       dir,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] period_count,
    output logic [4:0] period_len
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, UP, DOWN} state_t;

    state_t     state, state_nx;
    logic [2:0] prev;
    logic [2:0] exp_val;
    logic [4:0] scnt;
    logic       armed;
    logic       viol, valley, hold, stall_hit;
    logic       take, enter_acq, tracking;
    logic       lock_nx, dir_nx, err_nx;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

`ifdef TRI_SEQ_MON_STALL_EN
    assign stall_hit = (in_count == prev);
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        exp_val  = prev;
        viol     = 1'b0;
        valley   = 1'b0;
        hold     = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: state_nx = ACQUIRE;
                ACQUIRE: begin
                    if (prev != 3'd7 && in_count == prev + 3'd1)
                        state_nx = UP;
                    else if (prev != 3'd0 && in_count == prev - 3'd1)
                        state_nx = DOWN;
                end
                UP: begin
                    // Peak: the only legal continuation from 7 is 6, turning the ramp down
                    exp_val = (prev == 3'd7) ? 3'd6 : prev + 3'd1;
                    if (stall_hit)
                        hold = 1'b1;
                    else if (in_count == exp_val)
                        state_nx = (prev == 3'd7) ? DOWN : UP;
                    else begin
                        viol     = 1'b1;
                        state_nx = ACQUIRE;
                    end
                end
                DOWN: begin
                    exp_val = (prev == 3'd0) ? 3'd1 : prev - 3'd1;
                    if (stall_hit)
                        hold = 1'b1;
                    else if (in_count == exp_val) begin
                        valley   = (prev == 3'd0);
                        state_nx = (prev == 3'd0) ? UP : DOWN;
                    end else begin
                        viol     = 1'b1;
                        state_nx = ACQUIRE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        lock_nx = (state_nx == UP) || (state_nx == DOWN);
        dir_nx  = (state_nx == UP);
        err_nx  = viol;
    end

    assign take      = in_valid && !hold;
    assign enter_acq = (state_nx == ACQUIRE) && (state != ACQUIRE);
    assign tracking  = (state == UP) || (state == DOWN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock         <= 1'b0;
            dir          <= 1'b0;
            err          <= 1'b0;
            err_count    <= 8'd0;
            period_count <= 8'd0;
            period_len   <= 5'd0;
            prev         <= 3'd0;
            scnt         <= 5'd0;
            armed        <= 1'b0;
        end else begin
            lock <= lock_nx;
            dir  <= dir_nx;
            err  <= err_nx;
            if (take)
                prev <= in_count;
            if (viol)
                err_count <= sat_inc8(err_count);
            // A period is only measured between two valleys seen without losing lock
            if (take) begin
                if (enter_acq) begin
                    scnt  <= 5'd0;
                    armed <= 1'b0;
                end else if (valley) begin
                    scnt  <= 5'd1;
                    armed <= 1'b1;
                    if (armed) begin
                        period_count <= period_count + 8'd1;
                        period_len   <= scnt;
                    end
                end else if (tracking) begin
                    scnt <= sat_inc5(scnt);
                end
            end
        end
    end

endmodule
